// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data memory with a req/ready handshake, byte-enable
// writes and error flagging for misaligned or out-of-range byte addresses.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low reset
//   req    - access request, held with its fields until ready
//   we     - 1 = write, 0 = read
//   addr   - 32-bit byte address
//   wdata  - write data
//   be     - per-byte write enables (ignored on reads)
//   rdata  - registered read data, valid while ready=1, held afterwards
//   ready  - one-cycle completion pulse
//   err    - access error, valid only with ready
//   busy   - high whenever the controller is not idle
//
// Optional build macro DMEM_STATS_EN adds saturating 16-bit counters
// rd_cnt / wr_cnt / err_cnt of completed reads, writes and errored accesses.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]             rd_cnt,
  output logic [15:0]             wr_cnt,
  output logic [15:0]             err_cnt
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int HI    = ADDR_WIDTH + OFF;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           be_q, be_d;
  logic                    bad_q, bad_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    mem_wr;
  logic                    access;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Address decode on the live request; only used when latching in IDLE.
  logic                    addr_bad;
  logic [ADDR_WIDTH-1:0]   addr_idx;
  assign addr_bad = (addr[OFF-1:0] != '0) || ((addr >> HI) != 32'd0);
  assign addr_idx = addr[HI-1:OFF];

  // The access happens on the last WAIT edge (counter exhausted).
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

  // State register plus all datapath flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr_idx;
          wdata_d = wdata;
          be_d    = be;
          bad_d   = addr_bad;
          cnt_d   = 4'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          if (bad_q) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (we_q) begin
            mem_wr  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem[idx_q];
          end
        end
      end
      default: ;
    endcase
  end

  // RAM is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (reset && mem_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (access) begin
      if (bad_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  // Without stats, the access strobe has no consumer.
  logic unused_access;
  assign unused_access = access;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: three instances (LATENCY 2, 0, 15) share request
// fields but have separate req lines. A word/byte-level memory model with
// per-byte "known" tracking predicts rdata, err and completion latency.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_v;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata_v [3];
  logic [2:0]  ready_v, err_v, busy_v;
`ifdef DMEM_STATS_EN
  logic [15:0] rdc [3], wrc [3], erc [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 0 : 15)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req_v[g]),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata_v[g]),
      .ready (ready_v[g]),
      .err   (err_v[g]),
      .busy  (busy_v[g])
`ifdef DMEM_STATS_EN
      ,
      .rd_cnt  (rdc[g]),
      .wr_cnt  (wrc[g]),
      .err_cnt (erc[g])
`endif
    );
  end

  // Reference model
  logic [31:0] mm [3][256];
  logic [3:0]  kn [3][256];
  int          st [3][3];   // [dut][0=rd,1=wr,2=err]
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 15;
  endfunction

  // One complete transaction on DUT d, starting from an idle controller.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      output logic [31:0] rd, output logic e);
    int          cyc;
    logic        bad;
    logic        known;
    logic [7:0]  idx;
    logic [31:0] exp_rd;
    we = w; addr = a; wdata = wd; be = b; req_v[d] = 1'b1;
    @(posedge clk);
    // Fields are only used as latched; scramble them while busy.
    #1;
    we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    @(negedge clk);
    chk($sformatf("d%0d busy_wait", d), 32'(busy_v[d]), 32'd1);
    cyc = 1;
    while (!ready_v[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    req_v[d] = 1'b0;
    chk($sformatf("d%0d latency", d), cyc, lat_of(d) + 2);

    bad   = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    idx   = a[9:2];
    known = 1'b1;
    if (bad) begin
      exp_rd = 32'd0;
      st[d][2]++;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mm[d][idx][i*8 +: 8] = wd[i*8 +: 8];
      kn[d][idx] = kn[d][idx] | b;
      exp_rd = 32'd0;
      st[d][1]++;
    end else begin
      exp_rd = mm[d][idx];
      known  = (kn[d][idx] == 4'hF);
      st[d][0]++;
    end
    chk($sformatf("d%0d err @%h", d, a), 32'(err_v[d]), 32'(bad));
    if (known) chk($sformatf("d%0d rdata @%h", d, a), rdata_v[d], exp_rd);
    rd = rdata_v[d];
    e  = err_v[d];
    @(negedge clk);
    chk($sformatf("d%0d ready_pulse", d), 32'(ready_v[d]), 32'd0);
    chk($sformatf("d%0d busy_idle", d), 32'(busy_v[d]), 32'd0);
    chk($sformatf("d%0d rdata_hold", d), rdata_v[d], rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          rcnt;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) kn[d][i] = 4'h0;
      for (int k = 0; k < 3; k++) st[d][k] = 0;
    end
    reset = 1'b0; req_v = 3'b000; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d rst rdata", d), rdata_v[d], 32'd0);
      chk($sformatf("d%0d rst ready", d), 32'(ready_v[d]), 32'd0);
      chk($sformatf("d%0d rst err", d), 32'(err_v[d]), 32'd0);
      chk($sformatf("d%0d rst busy", d), 32'(busy_v[d]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Directed: write/read, byte enables, misaligned, out of range
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("dir rd 0x10", rd, 32'hDEADBEEF);
    chk("dir rd 0x10 err", 32'(e), 32'd0);
    xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, e);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("dir be merge", rd, 32'hDE22BE44);
    xact(0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, e);
    chk("dir misalign err", 32'(e), 32'd1);
    chk("dir misalign rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e);
    chk("dir after misalign", rd, 32'hDE22BE44);
    xact(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, e);
    chk("dir oor err", 32'(e), 32'd1);
    chk("dir oor rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, e);
    chk("dir top err", 32'(e), 32'd0);

    // Reset abort in the first WAIT cycle
    xact(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, e);
    we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; be = 4'hF; req_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_v[0] = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(ready_v[0]), 32'd0);
    chk("abort err", 32'(err_v[0]), 32'd0);
    chk("abort busy", 32'(busy_v[0]), 32'd0);
    chk("abort rdata", rdata_v[0], 32'd0);
    for (int d = 0; d < 3; d++) for (int k = 0; k < 3; k++) st[d][k] = 0;
    reset = 1'b1;
    rcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready_v[0]) rcnt++;
    end
    chk("abort no ready", rcnt, 0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, e);
    chk("abort old data", rd, 32'h0BADF00D);

    // Latency sweep: LATENCY=0 (d1) with 3 reads, 2 writes, 1 error
    xact(1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, e);
    xact(1, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, rd, e);
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, e);
    chk("l0 rd0", rd, 32'hA5A5A5A5);
    xact(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, e);
    chk("l0 rd4", rd, 32'h5A5A5A5A);
    xact(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, e);
    xact(1, 1'b0, 32'h401, 32'h0, 4'h0, rd, e);
    chk("l0 err", 32'(e), 32'd1);
`ifdef DMEM_STATS_EN
    chk("stats rd", 32'(rdc[1]), 32'd3);
    chk("stats wr", 32'(wrc[1]), 32'd2);
    chk("stats err", 32'(erc[1]), 32'd1);
`endif
    // LATENCY=15 (d2)
    xact(2, 1'b1, 32'h8, 32'h13579BDF, 4'hF, rd, e);
    xact(2, 1'b0, 32'h8, 32'h0, 4'h0, rd, e);
    chk("l15 rd", rd, 32'h13579BDF);

    // Randomized traffic checked against the model
    for (int n = 0; n < 60; n++) begin
      int          d;
      int          r;
      logic [31:0] a;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      r = $urandom_range(0, 9);
      if (r < 7)       a = {26'd0, 4'($urandom), 2'b00};
      else if (r == 7) a = {26'd0, 4'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'h400 | {$urandom_range(1, 255), 10'd0} | {22'd0, 8'($urandom), 2'b00};
      else             a = 32'h3FC;
      xact(d, 1'($urandom), a, $urandom, 4'($urandom), rd, e);
    end

`ifdef DMEM_STATS_EN
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d stats rd", d), 32'(rdc[d]), st[d][0]);
      chk($sformatf("d%0d stats wr", d), 32'(wrc[d]), st[d][1]);
      chk($sformatf("d%0d stats err", d), 32'(erc[d]), st[d][2]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
